conv_noise_channel: RTL and testbench
=====================================

Name: conv_noise_channel

Overview:
- Transmit half of the channel model: rate-1/2 convolutional encoder (K=3), pseudo-random noise injector and aligned output pipeline.
- Takes one data bit and one 8-bit random word per valid cycle.
- Emits the clean code pair, the corrupted code pair and the original bit, all time-aligned.
- Feeds the Viterbi decoder and the scoreboard.

Parameters:
- OUT_PIPE, 1, number of extra register stages on all outputs (>=1).
- CNT_W, 16, width of the injected-error counter.

Ports:
- clock  in  1  single clock, rising edge.
- rset  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  qualifies data_in/rand_in this cycle.
- data_in  in  1  original data bit.
- rand_in  in  8  random word for this bit's noise decision.
- error_level  in  8  noise threshold, quasi-static; sampled combinationally at the noise stage.
- out_valid  out  1  outputs below are valid.
- b_out  out  1  original bit, delayed to align with code outputs.
- c_out  out  2  clean encoded pair {c1,c0}.
- cx_out  out  2  corrupted pair = c_out ^ err.
- err_count  out  CNT_W  number of symbols corrupted since reset, saturating.

Behaviour:
- Reset: rset=0 immediately clears every register: pipeline data, valid bits, encoder state s[1:0], err_count and all outputs (0).
- Reset mid-stream: all in-flight symbols are discarded. The encoder restarts from state 00 on the first valid bit after release.
- Stage 1 (input register): on a clock edge, b1<=data_in, r1<=rand_in, v1<=in_valid.
- Encoder (combinational on stage-1 data): s1 is the previous bit, s0 the one before.
  - c0 = b1^s1^s0 (G0=111).
  - c1 = b1^s0 (G1=101).
  - When v1=1: s <= {b1,s1}. When v1=0 the state holds.
- Stage 2: c2<={c1,c0}, r2<=r1, b2<=b1, v2<=v1. Bubbles (v=0) pass with data registers still loaded; data is don't-care when v=0.
- Noise (combinational on r2):
  - If error_level==0 or r2>=error_level: err=00.
  - Else: if r2[1:0]==00 then err=11; else err = r2[0] ? 01 : 10.
  - The comparison is unsigned 8-bit. error_level=255 corrupts every r2<255.
- Stage 3: cx3<=c2^err, c3<=c2, b3<=b2, v3<=v2.
- err_count increments by 1 when v2=1 and err!=00. It saturates at all-ones and does not wrap.
- Output pipe: OUT_PIPE identical register stages carry {v3,b3,c3,cx3} to the outputs.
- Total latency from data_in sample edge to out_valid: 3+OUT_PIPE edges, i.e. 4 with the default.
- Throughput: one symbol per clock, no backpressure.
- Invalid cycles produce out_valid=0 and do not advance the encoder or err_count.

Decomposition:
- Shared package:
  - generator constants G0=3'b111, G1=3'b101
  - code_t (2-bit typedef)
  - function noise_mask(rand8, level8) returning code_t
- Sub-module noise_pipe_reg: width-parameterised register with async active-low clear and a depth parameter. Used for the input stage, stage registers and the OUT_PIPE chain.
- Encoder and noise logic stay inline.

Test Plan:
- Reset, then error_level=0, inputs 1,0,0,0 on consecutive valid cycles:
  - c_out = 11, 01, 11, 00.
  - cx_out equals c_out.
  - b_out = 1,0,0,0, first appearing 4 edges after the first sample.
  - err_count=0.
- error_level=255 with fixed data, rand_in = 0x00, 0x01, 0x02, 0xFF:
  - cx_out^c_out = 11, 01, 10, 00.
  - err_count=3.
- Boundary: error_level=5.
  - rand_in=4 -> corrupted.
  - rand_in=5 -> clean.
  - rand_in=6 -> clean.
- Bubbles: in_valid pattern 1,0,1 with data 1,x,1:
  - Encoder state skips the bubble, so outputs are 11 then 10.
  - out_valid = 1,0,1.
- Assert rset low mid-stream for part of a cycle:
  - All outputs and err_count go to 0 immediately.
  - After release, input 1 yields c_out=11 (state restarted from 00).
- Saturation: force 2^CNT_W+3 corrupted symbols (or use a small CNT_W) -> err_count holds at all-ones.

Source files
------------

// File: rtl/conv_noise_channel_pkg.sv
// rtl/conv_noise_channel_pkg.sv - shared generator constants, code type and noise mask for the channel model
// Contents:
//   code_t      : 2-bit code pair {c1,c0}
//   G0, G1      : generator taps applied to the window {b, s1, s0}
//   noise_mask  : error pattern for one symbol from its random word and the threshold
package conv_noise_channel_pkg;

  typedef logic [1:0] code_t;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  // A threshold of zero disables noise entirely; otherwise words below the
  // threshold corrupt the symbol. The low bits of the same word pick the pattern.
  function automatic code_t noise_mask(input logic [7:0] rand8, input logic [7:0] level8);
    code_t m;
    m = 2'b00;
    if ((level8 != 8'd0) && (rand8 < level8)) begin
      if (rand8[1:0] == 2'b00) m = 2'b11;
      else                     m = rand8[0] ? 2'b01 : 2'b10;
    end
    return m;
  endfunction

endpackage

// File: rtl/conv_noise_channel_pipe_reg.sv
// rtl/conv_noise_channel_pipe_reg.sv - DEPTH-stage register chain with asynchronous active-low clear
// Ports:
//   i_clock  : rising-edge clock
//   i_rset   : asynchronous clear, active low
//   i_d      : W-bit data into the first stage
//   o_q      : W-bit data out of the last stage
module noise_pipe_reg
  #(
    parameter int W     = 1,
    parameter int DEPTH = 1
  )
  (
    input  logic         i_clock,
    input  logic         i_rset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
  );

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clock or negedge i_rset) begin
    if (!i_rset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/conv_noise_channel.sv
// rtl/conv_noise_channel.sv - K=3 rate-1/2 encoder, noise injector and aligned output pipeline
// Ports:
//   clock       : rising-edge clock
//   rset        : asynchronous reset, active low
//   in_valid    : qualifies data_in / rand_in
//   data_in     : original data bit
//   rand_in     : 8-bit random word for this bit's noise decision
//   error_level : noise threshold, quasi-static
//   out_valid   : outputs below are valid
//   b_out       : original bit, aligned with the code outputs
//   c_out       : clean code pair {c1,c0}
//   cx_out      : corrupted code pair
//   err_count   : saturating count of corrupted symbols since reset
module conv_noise_channel
  import conv_noise_channel_pkg::*;
  #(
    parameter int OUT_PIPE = 1,
    parameter int CNT_W    = 16
  )
  (
    input  logic             clock,
    input  logic             rset,
    input  logic             in_valid,
    input  logic             data_in,
    input  logic [7:0]       rand_in,
    input  logic [7:0]       error_level,
    output logic             out_valid,
    output logic             b_out,
    output code_t            c_out,
    output code_t            cx_out,
    output logic [CNT_W-1:0] err_count
  );

  // Stage 1: {v, b, r}
  logic        w_v1;
  logic        w_b1;
  logic [7:0]  w_r1;

  noise_pipe_reg #(.W(10), .DEPTH(1)) u_stage1 (
    .i_clock (clock),
    .i_rset  (rset),
    .i_d     ({in_valid, data_in, rand_in}),
    .o_q     ({w_v1, w_b1, w_r1})
  );

  // Encoder state: r_state[1] = previous bit (s1), r_state[0] = the one before (s0).
  logic [1:0] r_state;
  logic [2:0] w_window;
  code_t      w_code;

  assign w_window = {w_b1, r_state};
  assign w_code   = {^(w_window & G1), ^(w_window & G0)};

  always_ff @(posedge clock or negedge rset) begin
    if (!rset)     r_state <= 2'b00;
    else if (w_v1) r_state <= {w_b1, r_state[1]};
  end

  // Stage 2: {v, b, r, code}
  logic        w_v2;
  logic        w_b2;
  logic [7:0]  w_r2;
  code_t       w_c2;
  code_t       w_err;

  noise_pipe_reg #(.W(12), .DEPTH(1)) u_stage2 (
    .i_clock (clock),
    .i_rset  (rset),
    .i_d     ({w_v1, w_b1, w_r1, w_code}),
    .o_q     ({w_v2, w_b2, w_r2, w_c2})
  );

  assign w_err = noise_mask(w_r2, error_level);

  // Stage 3 and the OUT_PIPE chain are identical registers, so one chain of
  // depth 1+OUT_PIPE carries {v, b, c, cx} straight to the outputs.
  noise_pipe_reg #(.W(6), .DEPTH(1 + OUT_PIPE)) u_out_pipe (
    .i_clock (clock),
    .i_rset  (rset),
    .i_d     ({w_v2, w_b2, w_c2, w_c2 ^ w_err}),
    .o_q     ({out_valid, b_out, c_out, cx_out})
  );

  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clock or negedge rset) begin
    if (!rset) begin
      r_err_cnt <= '0;
    end else if (w_v2 && (w_err != 2'b00) && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_conv_noise_channel.sv
// tb/tb_conv_noise_channel.sv - randomized scoreboard bench for conv_noise_channel
module tb_conv_noise_channel;

  localparam int OUT_PIPE = 1;
  localparam int CNT_W    = 4;
  localparam int LAT      = 2 + OUT_PIPE;
  localparam int MAXC     = 4096;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             rset  = 1'b0;
  logic             in_valid = 1'b0;
  logic             data_in  = 1'b0;
  logic [7:0]       rand_in  = 8'd0;
  logic [7:0]       error_level = 8'd0;
  logic             out_valid;
  logic             b_out;
  logic [1:0]       c_out;
  logic [1:0]       cx_out;
  logic [CNT_W-1:0] err_count;

  conv_noise_channel #(.OUT_PIPE(OUT_PIPE), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rset        (rset),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .rand_in     (rand_in),
    .error_level (error_level),
    .out_valid   (out_valid),
    .b_out       (b_out),
    .c_out       (c_out),
    .cx_out      (cx_out),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected output per input-sample edge index.
  bit       exp_v [MAXC];
  bit       exp_b [MAXC];
  bit [1:0] exp_c [MAXC];
  bit [1:0] exp_e [MAXC];
  bit       hist [$];
  int       model_cnt = 0;
  bit [1:0] obs_c [$];
  bit [1:0] obs_e [$];

  function automatic bit [1:0] ref_noise(input bit [7:0] r, input bit [7:0] lvl);
    if (lvl == 0 || r >= lvl) return 2'b00;
    if (r % 4 == 0) return 2'b11;
    return (r % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_push(input int k, input bit v, input bit d, input bit [7:0] r);
    bit p1, p2;
    if (k >= MAXC) return;
    exp_v[k] = v;
    if (v) begin
      p1 = (hist.size() > 0) ? hist[hist.size()-1] : 1'b0;
      p2 = (hist.size() > 1) ? hist[hist.size()-2] : 1'b0;
      exp_b[k] = d;
      exp_c[k] = {d ^ p2, d ^ p1 ^ p2};
      exp_e[k] = ref_noise(r, error_level);
      if (exp_e[k] != 2'b00 && model_cnt < CNT_MAX) model_cnt++;
      hist.push_back(d);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  task automatic model_clear(input int upto);
    for (int i = 0; i <= upto && i < MAXC; i++) exp_v[i] = 1'b0;
    hist.delete();
    model_cnt = 0;
  endtask

  task automatic check_outputs();
    int idx;
    bit ev;
    idx = cyc - LAT;
    ev  = (idx >= 0 && idx < MAXC) ? exp_v[idx] : 1'b0;
    check_val("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      check_val("b_out", {31'd0, b_out}, {31'd0, exp_b[idx]});
      check_val("c_out", {30'd0, c_out}, {30'd0, exp_c[idx]});
      check_val("cx_out", {30'd0, cx_out}, {30'd0, exp_c[idx] ^ exp_e[idx]});
    end
    if (out_valid) begin
      obs_c.push_back(c_out);
      obs_e.push_back(cx_out ^ c_out);
    end
  endtask

  task automatic step(input bit v, input bit d, input bit [7:0] r);
    @(negedge clock);
    in_valid = v;
    data_in  = d;
    rand_in  = r;
    model_push(cyc + 1, v, d, r);
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_b"},     {31'd0, b_out}, 32'd0);
    check_val({tag, "_c"},     {30'd0, c_out}, 32'd0);
    check_val({tag, "_cx"},    {30'd0, cx_out}, 32'd0);
    check_val({tag, "_cnt"},   {{(32-CNT_W){1'b0}}, err_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rset = 1'b0;
    in_valid = 1'b0;
    #1;
    check_zero("reset");
    model_clear(cyc + 1);
    @(negedge clock);
    rset = 1'b1;
    obs_c.delete();
    obs_e.delete();
  endtask

  // Pulse reset between edges, right after a step's sampling point.
  task automatic mid_reset();
    #1 rset = 1'b0;
    #1 check_zero("midrst");
    model_clear(cyc);
    #1 rset = 1'b1;
    obs_c.delete();
    obs_e.delete();
  endtask

  task automatic check_seq(input string tag, input bit [1:0] q[$], input bit [1:0] e[$]);
    check_val({tag, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check_val(tag, (i < q.size()) ? {30'd0, q[i]} : 32'hFFFF, {30'd0, e[i]});
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check_val(tag, {{(32-CNT_W){1'b0}}, err_count}, exp);
  endtask

  initial begin
    bit [7:0] lvls [4];
    bit [1:0] eq [$];

    #1;
    check_zero("init");

    // Encoder impulse response, no noise
    error_level = 8'd0;
    do_reset();
    step(1'b1, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    flush(5);
    check_seq("t1_c", obs_c, '{2'd3, 2'd1, 2'd3, 2'd0});
    check_seq("t1_err", obs_e, '{2'd0, 2'd0, 2'd0, 2'd0});
    check_cnt("t1_cnt", 0);

    // Noise patterns at full threshold
    error_level = 8'd255;
    do_reset();
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'hFF);
    flush(5);
    check_seq("t2_err", obs_e, '{2'd3, 2'd1, 2'd2, 2'd0});
    check_cnt("t2_cnt", 3);

    // Threshold boundary
    error_level = 8'd5;
    do_reset();
    step(1'b1, 1'b0, 8'd4);
    step(1'b1, 1'b1, 8'd5);
    step(1'b1, 1'b0, 8'd6);
    flush(5);
    check_seq("t3_err", obs_e, '{2'd3, 2'd0, 2'd0});
    check_cnt("t3_cnt", 1);

    // Bubble does not advance the encoder
    error_level = 8'd0;
    do_reset();
    step(1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd0);
    flush(5);
    check_seq("t4_c", obs_c, '{2'd3, 2'd2});

    // Randomized blocks with a mid-stream reset
    lvls[0] = 8'd0;
    lvls[1] = 8'd5;
    lvls[2] = 8'd255;
    lvls[3] = 8'($urandom_range(1, 254));
    do_reset();
    for (int b = 0; b < 4; b++) begin
      error_level = lvls[b];
      for (int n = 0; n < 150; n++) begin
        bit [7:0] r;
        r = (b == 1 && n % 2 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
        step(($urandom_range(0, 3) != 0), 1'($urandom), r);
        if (b == 2 && n == 70) begin
          mid_reset();
          step(1'b1, 1'b1, 8'hFF);
          flush(4);
          eq = '{2'd3};
          check_seq("rst_restart", obs_c, eq);
        end
      end
      flush(5);
      check_cnt("rand_cnt", model_cnt);
    end

    // Counter saturation
    error_level = 8'd255;
    do_reset();
    for (int n = 0; n < CNT_MAX + 5; n++) step(1'b1, 1'($urandom), 8'd0);
    flush(5);
    check_cnt("sat_cnt", CNT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
